// File: rtl/fft_pkg.sv
// Shared types and default sizing for the Fourier front-end blocks.
package fft_pkg;

    localparam int N_DEF = 16;
    localparam int W_DEF = 16;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_t;

endpackage

// File: rtl/sample_frame_buffer_if.sv
// Sample input stream and frame output bundle of the sample frame buffer.
interface sample_frame_buffer_if
    import fft_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic signed [W:0] in_re;
    logic signed [W:0] in_im;
    logic              in_last;
    logic              frame_valid;
    logic              frame_ready;
    logic signed [W:0] x_out [2*N];
    logic        [7:0] short_count;

    modport slave (
        input  in_valid, in_re, in_im, in_last, frame_ready,
        output in_ready, frame_valid, x_out, short_count
    );

    modport master (
        output in_valid, in_re, in_im, in_last, frame_ready,
        input  in_ready, frame_valid, x_out, short_count
    );

endinterface

// File: rtl/sample_bank.sv
// One frame bank: 2N entries, real parts low half, imaginary parts high half.
module sample_bank
    import fft_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF,
    localparam int IDX_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              zero,
    input  logic [IDX_W-1:0]  idx,
    input  logic signed [W:0] re,
    input  logic signed [W:0] im,
    output logic signed [W:0] data [2*N]
);

    logic signed [W:0] mem_q [2*N];
    logic signed [W:0] mem_d [2*N];

    // N is a power of two, so the imaginary slot is idx with the top bit set.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[{1'b0, idx}] = zero ? '0 : re;
            mem_d[{1'b1, idx}] = zero ? '0 : im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2*N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign data = mem_q;

endmodule

// File: rtl/sample_frame_buffer.sv
// Ping-pong frame assembler: fills one bank from the sample stream while the
// other is held for the matrix stage.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   FILL  | accepting samples into bank[wr_sel] while it is not full
//   PAD   | frame closed early by in_last; zero-filling the rest, in_ready=0
module sample_frame_buffer
    import fft_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    sample_frame_buffer_if.slave bus
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N-1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       full_q, full_d;
    logic [7:0]       short_q, short_d;

    logic accept;
    logic consume;
    logic we;
    logic zero;
    logic complete;

    logic signed [W:0] bank0_data [2*N];
    logic signed [W:0] bank1_data [2*N];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        full_d   = full_q;
        short_d  = short_q;
        accept   = 1'b0;
        we       = 1'b0;
        zero     = 1'b0;
        complete = 1'b0;
        consume  = full_q[rd_sel_q] && bus.frame_ready;

        case (state_q)
            FILL: begin
                accept = bus.in_valid && !full_q[wr_sel_q];
                we     = accept;
                if (accept) begin
                    // A full-length frame completes normally even if in_last is set.
                    if (idx_q == IDX_LAST) begin
                        complete = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (bus.in_last) begin
                            state_d = PAD;
                            if (short_q != 8'hFF) begin
                                short_d = short_q + 8'd1;
                            end
                        end
                    end
                end
            end
            PAD: begin
                we   = 1'b1;
                zero = 1'b1;
                if (idx_q == IDX_LAST) begin
                    complete = 1'b1;
                    state_d  = FILL;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = FILL;
        endcase

        // Consume and complete always target different banks.
        if (consume) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
        if (complete) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
            idx_d            = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            idx_q    <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            full_q   <= '0;
            short_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            full_q   <= full_d;
            short_q  <= short_d;
        end
    end

    sample_bank #(.N(N), .W(W)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we && !wr_sel_q),
        .zero  (zero),
        .idx   (idx_q),
        .re    (bus.in_re),
        .im    (bus.in_im),
        .data  (bank0_data)
    );

    sample_bank #(.N(N), .W(W)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we && wr_sel_q),
        .zero  (zero),
        .idx   (idx_q),
        .re    (bus.in_re),
        .im    (bus.in_im),
        .data  (bank1_data)
    );

    // in_ready depends only on registered state, never on frame_ready.
    assign bus.in_ready    = (state_q == FILL) && !full_q[wr_sel_q];
    assign bus.frame_valid = full_q[rd_sel_q];
    assign bus.short_count = short_q;

    always_comb begin
        for (int i = 0; i < 2*N; i++) begin
            bus.x_out[i] = rd_sel_q ? bank1_data[i] : bank0_data[i];
        end
    end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Directed bench for sample_frame_buffer with hand-computed expected frames.
module tb_sample_frame_buffer;
    import fft_pkg::*;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int WP = W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;

    sample_frame_buffer_if #(.N(N), .W(W)) sif ();

    sample_frame_buffer #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int xo(input int i);
        return int'(sif.x_out[i]);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int im, input bit last);
        int waited;
        waited = 0;
        sif.in_valid = 1'b1;
        sif.in_re    = WP'(re);
        sif.in_im    = WP'(im);
        sif.in_last  = last;
        while (!sif.in_ready && waited < 100) begin
            cycle();
            waited++;
        end
        if (!sif.in_ready) chk("accept_timeout", int'(sif.in_ready), 1);
        else cycle();
    endtask

    task automatic idle();
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
    endtask

    int stalls;
    int hs_n;
    int hs_cyc [8];
    int hs_x0  [8];
    int hs_x31 [8];
    int pad_n;

    initial begin
        sif.in_valid    = 1'b0;
        sif.in_re       = '0;
        sif.in_im       = '0;
        sif.in_last     = 1'b0;
        sif.frame_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", int'(sif.in_ready), 1);
        chk("rst_frame_valid", int'(sif.frame_valid), 0);
        chk("rst_x0", xo(0), 0);
        chk("rst_x31", xo(31), 0);
        chk("rst_short", int'(sif.short_count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single frame re=k, im=-k, consumer ready
        sif.frame_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            send(k, -k, 1'b0);
            if (k == N-2) chk("t1_fv_early", int'(sif.frame_valid), 0);
        end
        idle();
        chk("t1_fv", int'(sif.frame_valid), 1);
        chk("t1_x3", xo(3), 3);
        chk("t1_x19", xo(19), -3);
        cycle();
        chk("t1_fv_drop", int'(sif.frame_valid), 0);

        // 2: back-pressure with both banks full
        sif.frame_ready = 1'b0;
        for (int k = 0; k < 2*N; k++) send(k, k+100, 1'b0);
        sif.in_re = WP'(32);
        sif.in_im = WP'(132);
        chk("t2_ready_low", int'(sif.in_ready), 0);
        chk("t2_fv", int'(sif.frame_valid), 1);
        chk("t2_f0_x0", xo(0), 0);
        repeat (5) cycle();
        chk("t2_hold_ready", int'(sif.in_ready), 0);
        chk("t2_stable_x15", xo(15), 15);
        sif.frame_ready = 1'b1;
        cycle();
        sif.frame_ready = 1'b0;
        chk("t2_ready_rise", int'(sif.in_ready), 1);
        chk("t2_f1_x0", xo(0), 16);
        chk("t2_f1_x31", xo(31), 131);
        for (int k = 2*N; k < 3*N; k++) send(k, k+100, 1'b0);
        idle();
        chk("t2_full_again", int'(sif.in_ready), 0);
        sif.frame_ready = 1'b1;
        chk("t2_drain_f1", xo(5), 21);
        cycle();
        chk("t2_drain_f2", xo(5), 37);
        chk("t2_drain_f2_im", xo(21), 137);
        cycle();
        chk("t2_drain_empty", int'(sif.frame_valid), 0);
        sif.frame_ready = 1'b0;

        // 3: short frame closed by in_last on sample 4
        for (int k = 0; k < 5; k++) send(k, -k, k == 4);
        idle();
        chk("t3_pad_ready", int'(sif.in_ready), 0);
        chk("t3_short", int'(sif.short_count), 1);
        pad_n = 0;
        while (!sif.in_ready && pad_n < 40) begin
            cycle();
            pad_n++;
        end
        chk("t3_pad_cycles", pad_n, 11);
        chk("t3_fv", int'(sif.frame_valid), 1);
        chk("t3_x4", xo(4), 4);
        chk("t3_x5", xo(5), 0);
        chk("t3_x15", xo(15), 0);
        chk("t3_x20", xo(20), -4);
        chk("t3_x21", xo(21), 0);
        chk("t3_x31", xo(31), 0);
        sif.frame_ready = 1'b1;
        cycle();
        sif.frame_ready = 1'b0;

        // 4: continuous streaming, 4 frames, consumer always ready
        sif.frame_ready = 1'b1;
        stalls = 0;
        hs_n   = 0;
        fork
            begin
                for (int k = 0; k < 4*N; k++) begin
                    sif.in_valid = 1'b1;
                    sif.in_re    = WP'(200 + k);
                    sif.in_im    = WP'(-(200 + k));
                    if (!sif.in_ready) stalls++;
                    cycle();
                end
                idle();
            end
            begin
                repeat (90) begin
                    @(negedge clk);
                    if (sif.frame_valid && sif.frame_ready) begin
                        if (hs_n < 8) begin
                            hs_cyc[hs_n] = cyc_cnt;
                            hs_x0[hs_n]  = xo(0);
                            hs_x31[hs_n] = xo(31);
                        end
                        hs_n++;
                    end
                end
            end
        join
        sif.frame_ready = 1'b0;
        chk("t4_stalls", stalls, 0);
        chk("t4_handshakes", hs_n, 4);
        for (int f = 0; f < 4 && f < hs_n; f++) begin
            chk($sformatf("t4_f%0d_x0", f), hs_x0[f], 200 + 16*f);
            chk($sformatf("t4_f%0d_x31", f), hs_x31[f], -(215 + 16*f));
            if (f > 0) chk($sformatf("t4_gap%0d", f), hs_cyc[f] - hs_cyc[f-1], 16);
        end

        // 5: async reset mid-frame with one frame pending
        for (int k = 0; k < N; k++) send(300 + k, 0, 1'b0);
        for (int k = 0; k < 7; k++) send(400 + k, 1, 1'b0);
        idle();
        chk("t5_pending_fv", int'(sif.frame_valid), 1);
        chk("t5_pending_x0", xo(0), 300);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_fv", int'(sif.frame_valid), 0);
        chk("t5_rst_x0", xo(0), 0);
        chk("t5_rst_short", int'(sif.short_count), 0);
        chk("t5_rst_ready", int'(sif.in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < N; k++) send(500 + k, -(500 + k), 1'b0);
        idle();
        chk("t5_new_fv", int'(sif.frame_valid), 1);
        chk("t5_new_x0", xo(0), 500);
        chk("t5_new_x15", xo(15), 515);
        chk("t5_new_x16", xo(16), -500);
        sif.frame_ready = 1'b1;
        cycle();
        sif.frame_ready = 1'b0;
        chk("t5_drained", int'(sif.frame_valid), 0);

        // 6: in_last on the final index completes normally
        for (int k = 0; k < N; k++) send(600 + k, 7, k == N-1);
        idle();
        chk("t6_ready", int'(sif.in_ready), 1);
        chk("t6_fv", int'(sif.frame_valid), 1);
        chk("t6_short", int'(sif.short_count), 0);
        chk("t6_x15", xo(15), 615);
        chk("t6_x31", xo(31), 7);
        sif.frame_ready = 1'b1;
        cycle();
        sif.frame_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
